// File: rtl/teachee_stream_package.sv
// Shared definitions for the USB byte-stream path into the ft232h FIFO.
//   STREAM_DATA_WIDTH  width of the sys_axis byte stream
//   COBS_DELIMITER     frame delimiter byte that closes every COBS packet
//   stream_arb_state_t arbiter states: idle (arbitrating) or busy (streaming)
package teachee_stream_package;

    localparam int         STREAM_DATA_WIDTH = 8;
    localparam logic [7:0] COBS_DELIMITER    = 8'h00;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } stream_arb_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-stream stage carrying tdata + tlast.
// The output register is entry one; the skid register catches the single
// beat that can arrive while the output is stalled. Upstream ready depends
// only on local state, so ready paths never cross this stage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_last     upstream beat
//   s_valid/s_ready   upstream handshake (s_ready low only when both entries hold data)
//   m_data/m_last     registered downstream beat
//   m_valid/m_ready   downstream handshake
module axis_skid_buffer
    import teachee_stream_package::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;

    // The output register may take a new beat when it is empty or draining.
    logic out_free;
    logic load_skid;

    assign out_free  = !out_valid || m_ready;
    assign s_ready   = !skid_valid;
    assign load_skid = s_valid && s_ready && !out_free;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            // The idle bus parks the delimiter byte; any stray read is a frame boundary.
            out_data   <= DATA_WIDTH'(COBS_DELIMITER);
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Drain the skid entry first to keep beat order.
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= s_valid;
                if (s_valid) begin
                    out_data <= s_data;
                    out_last <= s_last;
                end
            end
        end else if (load_skid) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload needs no reset; skid_valid qualifies it, so
    // leaving it out of reset saves reset fan-out with no observable effect.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= s_data;
            skid_last <= s_last;
        end
    end

    assign m_valid = out_valid;
    assign m_data  = out_data;
    assign m_last  = out_last;

endmodule

// File: rtl/usb_stream_arbiter.sv
// Packet-aware round-robin arbiter sharing the single USB byte stream that
// feeds the ft232h FIFO among NUM_SOURCES packet producers.
// A grant is held from the first beat of a packet through its tlast beat,
// so bytes of two packets never interleave. The round-robin pointer moves
// only when a packet completes. Beats leave through a 2-entry skid buffer.
//
// Ports:
//   clk, rst     sys_clk, synchronous active-high reset
//   s_tdata      per-source bytes, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid     per-source valid
//   s_tlast      per-source end-of-packet (COBS delimiter beat)
//   s_tready     per-source ready, at most the granted bit is set
//   m_tdata      registered byte to the ft232h sys_axis sink
//   m_tvalid     registered output valid
//   m_tlast      registered output end-of-packet
//   m_tready     ft232h ready
//   grant_idx    current or most recent granted source
//   busy         high while a packet is being streamed
module usb_stream_arbiter
    import teachee_stream_package::*;
#(
    parameter int NUM_SOURCES = 2,
    parameter int DATA_WIDTH  = STREAM_DATA_WIDTH,
    localparam int IDX_W      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    output logic [NUM_SOURCES-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [IDX_W-1:0]                  grant_idx,
    output logic                              busy
);

    stream_arb_state_t state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]  grant_q, grant_nxt;

    logic                  sk_s_valid;
    logic                  sk_s_ready;
    logic [DATA_WIDTH-1:0] sk_s_data;
    logic                  sk_s_last;

    // First requesting source at or above ptr, wrapping modulo NUM_SOURCES.
    // Only called when at least one request is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_SOURCES-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cand = (int'(ptr) + i) % NUM_SOURCES;
            if (!found && req[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant_q <= grant_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_q;
        s_tready   = '0;
        sk_s_valid = 1'b0;
        sk_s_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        sk_s_last  = s_tlast[grant_q];

        case (state)
            S_IDLE: begin
                // Arbitration cycle: no ready is offered while the grant settles.
                if (|s_tvalid) begin
                    grant_nxt = rr_pick(s_tvalid, rr_ptr);
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                s_tready[grant_q] = sk_s_ready;
                sk_s_valid        = s_tvalid[grant_q];
                // The grant is released only by a completed tlast beat; a
                // source that pauses mid-packet keeps it.
                if (s_tvalid[grant_q] && sk_s_ready && s_tlast[grant_q]) begin
                    rr_ptr_nxt = IDX_W'((int'(grant_q) + 1) % NUM_SOURCES);
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (sk_s_data),
        .s_last  (sk_s_last),
        .s_valid (sk_s_valid),
        .s_ready (sk_s_ready),
        .m_data  (m_tdata),
        .m_last  (m_tlast),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

    assign grant_idx = grant_q;
    assign busy      = (state == S_BUSY);

endmodule

// File: tb/tb_usb_stream_arbiter.sv
module tb_usb_stream_arbiter;

    localparam int NSRC = 2;
    localparam int DW   = 8;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NSRC*DW-1:0] s_tdata;
    logic [NSRC-1:0]  s_tvalid;
    logic [NSRC-1:0]  s_tlast;
    logic [NSRC-1:0]  s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic             grant_idx;
    logic             busy;

    int errors = 0;
    int checks = 0;

    beat_t src_q [NSRC][$];
    beat_t pend  [NSRC][$];
    beat_t exp_q [$];
    int    sent  [NSRC];

    bit rdy_mode  = 1'b0;
    bit sb_en     = 1'b0;
    bit gap_en    = 1'b0;
    bit have_prev = 1'b0;

    usb_stream_arbiter #(
        .NUM_SOURCES (NSRC),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Source and sink driver: handshakes are judged from the stable values
    // seen at the falling edge, inputs change just after the rising edge.
    initial begin : driver
        logic [NSRC-1:0] hs;
        beat_t           b;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        sent     = '{default: 0};
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NSRC; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    sent[i]++;
                end
                if (src_q[i].size() > 0 && src_q[i][0].gap > 0) begin
                    b = src_q[i][0];
                    b.gap--;
                    src_q[i][0] = b;
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end else if (src_q[i].size() > 0) begin
                    s_tvalid[i]         = 1'b1;
                    s_tdata[i*DW +: DW] = src_q[i][0].data;
                    s_tlast[i]          = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard against exp_q, stall stability, beat spacing.
    initial begin : monitor
        int         cyc = 0;
        int         prev_cyc = 0;
        int         want;
        bit         prev_last = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        beat_t      e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && prev_stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                             m_tvalid, m_tdata, m_tlast, pd, pl);
                end
            end
            prev_stall = !rst && m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            if (!rst && sb_en && m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got d=%h l=%b, expected no beat", m_tdata, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL stream_beat: got d=%h l=%b, expected d=%h l=%b",
                                 m_tdata, m_tlast, e.data, e.last);
                    end
                end
                if (gap_en && have_prev) begin
                    want = prev_last ? prev_cyc + 2 : prev_cyc + 1;
                    checks++;
                    if (cyc != want) begin
                        errors++;
                        $display("FAIL beat_spacing: got cycle %0d, expected cycle %0d", cyc, want);
                    end
                end
                have_prev = 1'b1;
                prev_cyc  = cyc;
                prev_last = m_tlast;
            end
        end
    end

    task automatic add_packet(input int src, input int len, input int gap_at, input int gap_len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = 8'($urandom_range(0, 255));
            b.last = (j == len - 1);
            b.gap  = (j == gap_at) ? gap_len : 0;
            src_q[src].push_back(b);
            pend[src].push_back(b);
        end
    endtask

    // Reference order: whole packets, first pending source from the pointer
    // upward, pointer moves to one past the source that just finished.
    task automatic run_model();
        int    ptr = 0;
        int    pick;
        int    total;
        beat_t b;
        total = 0;
        for (int i = 0; i < NSRC; i++) total += pend[i].size();
        while (total > 0) begin
            pick = -1;
            for (int off = 0; off < NSRC; off++)
                if (pick < 0 && pend[(ptr + off) % NSRC].size() > 0) pick = (ptr + off) % NSRC;
            do begin
                b = pend[pick].pop_front();
                exp_q.push_back(b);
                total--;
            end while (!b.last);
            ptr = (pick + 1) % NSRC;
        end
    endtask

    task automatic do_reset();
        rdy_mode = 1'b0;
        sb_en    = 1'b0;
        gap_en   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            pend[i].delete();
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        sent      = '{default: 0};
        have_prev = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        add_packet(0, 3, -1, 0);
        add_packet(1, 3, -1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 4;
            if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b, expected 00", s_tready); end
            if (m_tvalid !== 1'b0)  begin errors++; $display("FAIL reset_mvalid: got %b, expected 0", m_tvalid); end
            if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
            if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b, expected 0", grant_idx); end
        end
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            pend[i].delete();
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL idle_mvalid: got %b, expected 0", m_tvalid); end
    endtask

    task automatic test_single();
        logic [7:0] bytes [5];
        beat_t      b;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        do_reset();
        sb_en  = 1'b1;
        gap_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            b.data = bytes[j];
            b.last = (j == 4);
            b.gap  = 0;
            src_q[0].push_back(b);
            exp_q.push_back(b);
        end
        @(negedge clk);
        checks += 2;
        if (s_tready !== 2'b00) begin errors++; $display("FAIL arb_cycle_tready: got %b, expected 00", s_tready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL arb_cycle_busy: got %b, expected 0", busy); end
        @(negedge clk);
        checks += 3;
        if (s_tready !== 2'b01) begin errors++; $display("FAIL grant_tready: got %b, expected 01", s_tready); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL grant_busy: got %b, expected 1", busy); end
        if (grant_idx !== 1'b0) begin errors++; $display("FAIL grant_idx0: got %b, expected 0", grant_idx); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_tvalid) begin
                checks++;
                if (busy !== !m_tlast) begin
                    errors++;
                    $display("FAIL busy_track: got busy=%b, expected %b", busy, !m_tlast);
                end
                if (m_tlast) break;
            end
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_done: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        for (int trial = 0; trial < 4; trial++) begin
            do_reset();
            rdy_mode = (trial == 3);
            gap_en   = (trial != 3);
            sb_en    = 1'b1;
            for (int s = 0; s < NSRC; s++) begin
                n = (trial == 0) ? 2 : $urandom_range(1, 3);
                for (int p = 0; p < n; p++)
                    add_packet(s, (trial == 0) ? 3 : $urandom_range(1, 4), -1, 0);
            end
            run_model();
            for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL rr_done trial %0d: got %0d beats left, expected 0", trial, exp_q.size());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_mode = 1'b1;
        sb_en    = 1'b1;
        add_packet(1, 64, -1, 0);
        run_model();
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_packet(0, 8, -1, 0);
        pend[0].delete();
        for (int k = 0; k < 50 && sent[0] < 2; k++) @(negedge clk);
        rst = 1'b1;
        src_q[0].delete();
        add_packet(1, 2, -1, 0);
        @(negedge clk);
        checks += 2;
        if (m_tvalid !== 1'b0)  begin errors++; $display("FAIL rst_mid_mvalid: got %b, expected 0", m_tvalid); end
        if (s_tready !== 2'b00) begin errors++; $display("FAIL rst_mid_tready: got %b, expected 00", s_tready); end
        rst       = 1'b0;
        have_prev = 1'b0;
        run_model();
        sb_en     = 1'b1;
        @(negedge clk);
        checks += 2;
        if (grant_idx !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %b, expected 1", grant_idx); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL rst_mid_busy: got %b, expected 1", busy); end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_done: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stalled_grant();
        do_reset();
        sb_en = 1'b1;
        add_packet(0, 6, 3, 10);
        add_packet(1, 3, -1, 0);
        run_model();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sent[0] >= 6) break;
            checks++;
            if (s_tready[1] !== 1'b0) begin
                errors++;
                $display("FAIL stall_src1_ready: got %b, expected 0", s_tready[1]);
            end
            if (sent[0] >= 1) begin
                checks += 2;
                if (busy !== 1'b1)      begin errors++; $display("FAIL stall_busy: got %b, expected 1", busy); end
                if (grant_idx !== 1'b0) begin errors++; $display("FAIL stall_grant: got %b, expected 0", grant_idx); end
            end
        end
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_stalled_grant();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
